// File: rtl/sel_enc_pkg.sv
// Shared constants, field-select enum and one-hot helper for the register
// select/encode unit and its scoreboard.
package sel_enc_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG   = 16;
  localparam int DEF_IDX_W  = 4;
  localparam int DEF_RA_LSB = 23;
  localparam int DEF_RB_LSB = 19;
  localparam int DEF_RC_LSB = 15;
  localparam int DEF_C_W    = 19;

  // Upper bound on register-file size served by the one-hot helper.
  localparam int ONEHOT_MAX = 256;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_B,
    SEL_C
  } sel_e;

  // Callers truncate the result to their own register count.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
    return ONEHOT_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_select_scoreboard_onehot_decoder.sv
// Enabled index-to-one-hot decoder (IDX_W -> NREG); all zeros when disabled.
module onehot_decoder
  import sel_enc_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int NREG  = DEF_NREG
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [NREG-1:0]  onehot_o
);

  assign onehot_o = en_i ? NREG'(onehot(32'(idx_i))) : '0;

endmodule

// File: rtl/reg_select_scoreboard.sv
// Register select/encode unit: latched IR, prioritised Ra/Rb/Rc decode to
// one-hot register enables, C sign-extension and a busy-bit hazard scoreboard.
// Define REG_SELECT_REGOUT_EN to register r_in_sel/r_out_sel/ba_zero (1 clk).
module reg_select_scoreboard
  import sel_enc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int RA_LSB = DEF_RA_LSB,
  parameter int RB_LSB = DEF_RB_LSB,
  parameter int RC_LSB = DEF_RC_LSB,
  parameter int C_W    = DEF_C_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] ir_in,
  input  logic              ir_load,
  input  logic              gra,
  input  logic              grb,
  input  logic              grc,
  input  logic              rin,
  input  logic              rout,
  input  logic              baout,
  input  logic              issue,
  input  logic              retire,
  input  logic [IDX_W-1:0]  retire_idx,
  output logic [NREG-1:0]   r_in_sel,
  output logic [NREG-1:0]   r_out_sel,
  output logic              ba_zero,
  output logic [DATA_W-1:0] c_ext,
  output logic              hazard,
  output logic [NREG-1:0]   busy
);

  logic [DATA_W-1:0] ir_q;
  logic [IDX_W-1:0]  ra, rb, rc;
  sel_e              sel;
  logic [IDX_W-1:0]  sel_idx;
  logic [NREG-1:0]   sel_oh;
  logic [NREG-1:0]   r_in_sel_d, r_out_sel_d;
  logic              ba_zero_d;
  logic [NREG-1:0]   ret_mask, eff, iss_mask;
  logic [NREG-1:0]   busy_d, busy_q;
  logic              unused_ir;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ir_q <= '0;
    end else if (ir_load) begin
      ir_q <= ir_in;
    end
  end

  // Not every IR bit feeds a field; fold them so the slice stays referenced.
  assign unused_ir = ^ir_q;

  assign ra = ir_q[RA_LSB +: IDX_W];
  assign rb = ir_q[RB_LSB +: IDX_W];
  assign rc = ir_q[RC_LSB +: IDX_W];

  // Stage p0: strobe priority gra > grb > grc, then decode from latched IR
  always_comb begin
    sel = SEL_NONE;
    if (gra)      sel = SEL_A;
    else if (grb) sel = SEL_B;
    else if (grc) sel = SEL_C;
  end

  always_comb begin
    sel_idx = '0;
    case (sel)
      SEL_A:   sel_idx = ra;
      SEL_B:   sel_idx = rb;
      SEL_C:   sel_idx = rc;
      default: sel_idx = '0;
    endcase
  end

  onehot_decoder #(.IDX_W(IDX_W), .NREG(NREG)) u_sel_dec (
    .idx_i    (sel_idx),
    .en_i     (sel != SEL_NONE),
    .onehot_o (sel_oh)
  );

  assign ba_zero_d   = baout && (sel != SEL_NONE) && (sel_idx == '0);
  assign r_in_sel_d  = rin ? sel_oh : '0;
  assign r_out_sel_d = ((rout || baout) && !ba_zero_d) ? sel_oh : '0;

`ifdef REG_SELECT_REGOUT_EN
  logic [NREG-1:0] r_in_sel_q, r_out_sel_q;
  logic            ba_zero_q;

  // Stage p1: registered select outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_in_sel_q  <= '0;
      r_out_sel_q <= '0;
      ba_zero_q   <= 1'b0;
    end else begin
      r_in_sel_q  <= r_in_sel_d;
      r_out_sel_q <= r_out_sel_d;
      ba_zero_q   <= ba_zero_d;
    end
  end

  assign r_in_sel  = r_in_sel_q;
  assign r_out_sel = r_out_sel_q;
  assign ba_zero   = ba_zero_q;
`else
  assign r_in_sel  = r_in_sel_d;
  assign r_out_sel = r_out_sel_d;
  assign ba_zero   = ba_zero_d;
`endif

  assign c_ext = {{(DATA_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

  // Retire is forwarded into the hazard check so writeback frees a register
  // in the same cycle that a dependent instruction tries to issue.
  onehot_decoder #(.IDX_W(IDX_W), .NREG(NREG)) u_ret_dec (
    .idx_i    (retire_idx),
    .en_i     (retire),
    .onehot_o (ret_mask)
  );

  assign eff      = busy_q & ~ret_mask;
  assign hazard   = issue && (eff[ra] || eff[rb] || eff[rc]);
  assign iss_mask = (issue && !hazard) ? NREG'(onehot(32'(ra))) : '0;
  assign busy_d   = eff | iss_mask;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule
